ft232h_rx_ctrl: RTL
===================

FT232H_RX_CTRL -- requirements
Module: ft232h_rx_ctrl

Interface
REQ-001 SHALL have parameter SKID_DEPTH, default 4, depth of the internal receive buffer (power of two, >= 4).
REQ-002 SHALL have port clk, input, 1, the single clock, also the FT232H 60 MHz CLKOUT domain.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port rxf_n, input, 1, FT232H receive-FIFO-has-data, active low.
REQ-005 SHALL have port data, input, 8, FT232H data bus as seen by the FPGA; the tristate is handled outside this block.
REQ-006 SHALL have port oe_n, output, 1, FT232H output enable, active low.
REQ-007 SHALL have port rd_n, output, 1, FT232H read strobe, active low.
REQ-008 SHALL have port tdata, output, 8, received byte towards the FPGA fabric.
REQ-009 SHALL have port tvalid, output, 1, AXI-stream valid.
REQ-010 SHALL have port tready, input, 1, AXI-stream ready.
REQ-011 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-012 SHALL run an FSM with states IDLE, OE_ASSERT, READING; all transitions occur on the rising clk edge.
REQ-013 IDLE: oe_n=1, rd_n=1; go to OE_ASSERT when rxf_n==0 and the buffer holds >= 3 free entries.
REQ-014 OE_ASSERT: oe_n=0, rd_n=1 for exactly one cycle, then unconditionally go to READING (bus turnaround).
REQ-015 READING: oe_n=0, rd_n=0; on each edge where rd_n==0 and rxf_n==0, data SHALL be pushed into the buffer.
REQ-016 READING SHALL return to IDLE, with oe_n and rd_n both 1 from the following cycle, when rxf_n==1 or the buffer will have <= 1 free entry after this cycle's push/pop.
REQ-017 No byte SHALL be sampled in IDLE or OE_ASSERT, nor when rxf_n==1.
REQ-018 A byte SHALL appear on tdata/tvalid no earlier than 1 cycle after it is sampled; bytes SHALL exit in arrival order, with none lost or duplicated.
REQ-019 tvalid SHALL be high exactly when the buffer is non-empty; a pop occurs on an edge with tvalid && tready.
REQ-020 tdata SHALL remain stable while tvalid==1 and tready==0.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged and be legal when the buffer is full.
REQ-022 Buffer pointers SHALL wrap modulo SKID_DEPTH; occupancy SHALL be a $clog2(SKID_DEPTH)+1-bit counter.
REQ-023 A push into a full buffer without a simultaneous pop SHALL drop the byte and set overflow; overflow remains 1 until rst.
REQ-024 A deassertion of rxf_n in the same cycle as OE_ASSERT SHALL still pass through READING for one cycle with no sample taken.

Reset
REQ-025 While rst==1: state=IDLE, oe_n=1, rd_n=1, tvalid=0, buffer empty, overflow=0, tdata=8'h00.
REQ-026 An rst asserted mid-READING SHALL drive oe_n=1 and rd_n=1 at the next edge and discard all buffered bytes.

Structure
REQ-027 The state enum ft232h_rx_state_t and the bus width constant FT232H_DATA_W=8 SHALL live in shared package ft232h_pkg.
REQ-028 The buffer SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/count) reusable by a future TX controller.
REQ-029 Target size is 120-400 RTL lines in total.

Verification
REQ-030 Reset: hold rst for 2 cycles with rxf_n=0 -> oe_n=1, rd_n=1, tvalid=0, overflow=0 throughout.
REQ-031 Single byte, tready=1: rxf_n low for one READING cycle with data=8'h45 -> oe_n falls at cycle 1, rd_n falls at cycle 2, tdata=8'h45 with tvalid for 1 cycle, then IDLE.
REQ-032 Burst 8'h45..8'h4C with tready=1 -> 8 bytes out in order, no gaps after the first, overflow=0.
REQ-033 Backpressure: tready=0, 10 bytes pending -> rd_n deasserts once occupancy reaches SKID_DEPTH-1; no drop; after tready=1 all 10 bytes arrive in order.
REQ-034 Reset mid-burst after 2 bytes -> oe_n and rd_n are high at the next edge, tvalid=0, and no stale bytes appear after rst releases.
REQ-035 rxf_n glitch: rxf_n=0 for only the IDLE->OE_ASSERT cycle -> zero bytes sampled, FSM returns to IDLE within 3 cycles.

Source files
------------

// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H synchronous-FIFO controllers.
package ft232h_pkg;
  localparam int FT232H_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    OE_ASSERT,
    READING
  } ft232h_rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push into a full FIFO is ignored
// unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ft232h_rx_ctrl.sv
// FT232H synchronous-FIFO receive controller: reads bytes from the chip
// and presents them on an AXI-stream style interface through a skid buffer.
module ft232h_rx_ctrl
  import ft232h_pkg::*;
#(
  parameter int SKID_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxf_n,
  input  logic [FT232H_DATA_W-1:0] data,
  output logic                     oe_n,
  output logic                     rd_n,
  output logic [FT232H_DATA_W-1:0] tdata,
  output logic                     tvalid,
  input  logic                     tready,
  output logic                     overflow
);
  localparam int CW = $clog2(SKID_DEPTH) + 1;

  ft232h_rx_state_t         state;
  ft232h_rx_state_t         next_state;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free;
  logic [CW-1:0]            occ_next;
  logic [CW-1:0]            free_next;
  logic [FT232H_DATA_W-1:0] fifo_dout;

  sync_fifo #(
    .WIDTH (FT232H_DATA_W),
    .DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign tvalid = !empty && !rst;
  assign tdata  = tvalid ? fifo_dout : '0;
  assign pop    = tvalid && tready;
  assign free   = CW'(SKID_DEPTH) - count;

  // Occupancy after this cycle's push/pop decides whether READING may continue.
  always_comb begin
    occ_next = count;
    if (push && (!full || pop)) occ_next = occ_next + 1'b1;
    if (pop)                    occ_next = occ_next - 1'b1;
    free_next = CW'(SKID_DEPTH) - occ_next;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    oe_n       = 1'b1;
    rd_n       = 1'b1;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!rxf_n && free >= CW'(3)) next_state = OE_ASSERT;
      end
      OE_ASSERT: begin
        oe_n       = 1'b0;
        next_state = READING;
      end
      READING: begin
        oe_n = 1'b0;
        rd_n = 1'b0;
        push = !rxf_n;
        if (rxf_n || free_next <= CW'(1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) begin
      oe_n = 1'b1;
      rd_n = 1'b1;
      push = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end
endmodule
